// File: rtl/instruction_fetch_phase_pkg.sv
// Shared CPU front-end definitions: word width, reset/bubble constants,
// fetch FSM states and the next-PC select encoding.
package cpu_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        BOOT,
        RUN
    } if_state_e;

    typedef enum logic [1:0] {
        SEQ,
        BR,
        J,
        JR
    } pc_sel_e;

    // Redirect targets are word addresses; the low two bits are dropped.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_phase_if.sv
// Fetch-stage bus: hazard/redirect controls from decode, instruction memory
// port and the IF/ID outputs. master = fetch stage, slave = surrounding core.
interface instruction_fetch_phase_if;
    import cpu_pkg::*;

    logic                Stall;
    logic                Flush;
    logic                Branch;
    logic [WORD_W-1:0]   BranchTarget;
    logic                Jump;
    logic [WORD_W-1:0]   JumpTarget;
    logic                JumpRegister;
    logic [WORD_W-1:0]   JumpRegTarget;
    logic [WORD_W-1:0]   imem_addr;
    logic [WORD_W-1:0]   imem_data;
    logic [WORD_W-1:0]   instr_out;
    logic [WORD_W-1:0]   pc_out;
    logic                valid_out;
    logic                misalign_err;
    logic [WORD_W-1:0]   fetch_count;
    if_state_e           state;

    modport master (
        input  Stall, Flush, Branch, BranchTarget, Jump, JumpTarget,
               JumpRegister, JumpRegTarget, imem_data,
        output imem_addr, instr_out, pc_out, valid_out, misalign_err,
               fetch_count, state
    );

    modport slave (
        output Stall, Flush, Branch, BranchTarget, Jump, JumpTarget,
               JumpRegister, JumpRegTarget, imem_data,
        input  imem_addr, instr_out, pc_out, valid_out, misalign_err,
               fetch_count, state
    );

endinterface

// File: rtl/instruction_fetch_phase_if_id_register.sv
// IF/ID pipeline register. Flush wins over stall so a bubble can be
// inserted while the PC is frozen.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/instruction_fetch_phase.sv
// Instruction fetch stage: PC register, next-PC select, BOOT/RUN FSM,
// sticky misalignment flag, fetch counter and the IF/ID register.
module instruction_fetch_phase #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                        Clk,
    input  logic                        Reset,
    instruction_fetch_phase_if.master   bus
);

    cpu_pkg::if_state_e state_q, state_d;
    cpu_pkg::pc_sel_e   pc_sel;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        fetch_count_q, fetch_count_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        raw_target;
    logic [31:0]        pc_plus4;
    logic               advance;
    logic               redirect;
    logic               bubble;
    logic               load_valid;

    always_comb begin
        pc_sel     = cpu_pkg::SEQ;
        raw_target = 32'd0;
        if (bus.JumpRegister) begin
            pc_sel     = cpu_pkg::JR;
            raw_target = bus.JumpRegTarget;
        end else if (bus.Jump) begin
            pc_sel     = cpu_pkg::J;
            raw_target = bus.JumpTarget;
        end else if (bus.Branch) begin
            pc_sel     = cpu_pkg::BR;
            raw_target = bus.BranchTarget;
        end
    end

    assign pc_plus4   = pc_q + 32'd4;
    // Redirects only count when the stage actually advances; a stalled decode
    // re-presents the same redirect next cycle.
    assign advance    = (state_q == cpu_pkg::RUN) && !bus.Stall;
    assign redirect   = advance && (pc_sel != cpu_pkg::SEQ);
    assign bubble     = (state_q == cpu_pkg::BOOT) || bus.Flush || redirect;
    assign load_valid = advance && !bus.Flush && !redirect;

    always_comb begin
        state_d       = cpu_pkg::RUN;
        pc_d          = pc_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            pc_d       = cpu_pkg::align_word(raw_target);
            misalign_d = misalign_q || (raw_target[1:0] != 2'b00);
        end else if (advance) begin
            pc_d = pc_plus4;
        end
        if (load_valid) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= cpu_pkg::BOOT;
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (Clk),
        .rst_n       (Reset),
        .stall       (bus.Stall),
        .flush       (bubble),
        .instr_in    (bus.imem_data),
        .pc_plus4_in (pc_plus4),
        .instr       (ifid_instr),
        .pc_plus4    (ifid_pc),
        .valid       (ifid_valid)
    );

    assign bus.imem_addr    = pc_q;
    assign bus.instr_out    = ifid_instr;
    assign bus.pc_out       = ifid_pc;
    assign bus.valid_out    = ifid_valid;
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_count  = fetch_count_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Directed bench for instruction_fetch_phase: each cycle pushes its expected
// post-edge snapshot; a monitor pops and compares one entry per rising edge.
module tb_instruction_fetch_phase;
  import cpu_pkg::*;

  logic clk_r = 1'b0;
  logic rst_r = 1'b1;
  always #5 clk_r = ~clk_r;

  instruction_fetch_phase_if bus();

  instruction_fetch_phase dut (
    .Clk   (clk_r),
    .Reset (rst_r),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return {8'hA5, a[23:0]};
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected snapshot per rising edge while entries are queued.
  always @(posedge clk_r) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", 32'(bus.state), 32'(RUN));
      chk("imem_addr", bus.imem_addr, e.addr);
      chk("instr_out", bus.instr_out, e.instr);
      chk("pc_out", bus.pc_out, e.pc);
      chk("valid_out", 32'(bus.valid_out), 32'(e.valid));
      chk("misalign_err", 32'(bus.misalign_err), 32'(e.mis));
      chk("fetch_count", bus.fetch_count, e.cnt);
    end
  end

  // Called at a falling edge: drive controls, queue expected post-edge state.
  task automatic step(input logic s, f, b, j, r,
                      input logic [31:0] bt, jt, jrt,
                      input logic [31:0] e_addr, e_pc,
                      input logic e_v, input logic [31:0] e_cnt, input logic e_m);
    exp_t e;
    bus.Stall = s; bus.Flush = f;
    bus.Branch = b; bus.BranchTarget = bt;
    bus.Jump = j; bus.JumpTarget = jt;
    bus.JumpRegister = r; bus.JumpRegTarget = jrt;
    e.addr  = e_addr;
    e.pc    = e_pc;
    e.valid = e_v;
    e.instr = e_v ? mem_word(e_pc - 32'd4) : NOP_INSTR;
    e.mis   = e_m;
    e.cnt   = e_cnt;
    exp_q.push_back(e);
    @(posedge clk_r);
    @(negedge clk_r);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
    chk({tag, "_instr_out"}, bus.instr_out, NOP_INSTR);
    chk({tag, "_pc_out"}, bus.pc_out, 32'd0);
    chk({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    chk({tag, "_misalign"}, 32'(bus.misalign_err), 32'd0);
    chk({tag, "_fetch_count"}, bus.fetch_count, 32'd0);
    chk({tag, "_state"}, 32'(bus.state), 32'(BOOT));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Stall = 0; bus.Flush = 0; bus.Branch = 0; bus.Jump = 0; bus.JumpRegister = 0;
    bus.BranchTarget = 0; bus.JumpTarget = 0; bus.JumpRegTarget = 0;
    #1 rst_r = 1'b0;
    #2 chk_reset_vals("por");

    @(negedge clk_r);
    rst_r = 1'b1;
    //    S  F  B  J  R   BT      JT      JRT          addr    pc_out  v  cnt m
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h0,  32'h0,  0, 0, 0); // BOOT->RUN
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h4,  32'h4,  1, 1, 0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h8,  32'h8,  1, 2, 0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'hC,  32'hC,  1, 3, 0);
    // PC=0xC: branch to 0x40 costs one bubble
    step(0, 0, 1, 0, 0, 32'h40, 32'h0, 32'h0,       32'h40, 32'h0,  0, 3, 0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h44, 32'h44, 1, 4, 0);
    // JR beats J
    step(0, 0, 0, 1, 1, 32'h0, 32'h200, 32'h100,    32'h100, 32'h0, 0, 4, 0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h104, 32'h104, 1, 5, 0);
    step(0, 0, 0, 1, 1, 32'h0, 32'h200, 32'h103,    32'h100, 32'h0, 0, 5, 1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h104, 32'h104, 1, 6, 1);
    // Stall ignores the branch and holds everything
    step(1, 0, 1, 0, 0, 32'h80, 32'h0, 32'h0,       32'h104, 32'h104, 1, 6, 1);
    step(1, 0, 1, 0, 0, 32'h80, 32'h0, 32'h0,       32'h104, 32'h104, 1, 6, 1);
    step(1, 0, 1, 0, 0, 32'h80, 32'h0, 32'h0,       32'h104, 32'h104, 1, 6, 1);
    step(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h104, 32'h0, 0, 6, 1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h108, 32'h108, 1, 7, 1);
    // Plain flush: PC advances, bubble inserted
    step(0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h10C, 32'h0, 0, 7, 1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h110, 32'h110, 1, 8, 1);
    // Flush + branch: PC redirects, bubble
    step(0, 1, 1, 0, 0, 32'h80, 32'h0, 32'h0,       32'h80, 32'h0,  0, 8, 1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h84, 32'h84, 1, 9, 1);
    // J beats branch
    step(0, 0, 1, 1, 0, 32'h400, 32'h300, 32'h0,    32'h300, 32'h0, 0, 9, 1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h304, 32'h304, 1, 10, 1);

    // Mid-cycle asynchronous reset while valid_out=1
    #2 rst_r = 1'b0;
    #1 chk_reset_vals("midrst");

    @(negedge clk_r);
    rst_r = 1'b1;
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h0,  32'h0,  0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h0,  32'h0,  1, 1, 0); // PC+4 wraps
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h4,  32'h4,  1, 2, 0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
